// File: rtl/line_mem_responder.sv
// line_mem_responder: single-outstanding, line-granular memory model.
// One 128-bit line (4 x 32-bit words) is served per request after a fixed
// latency. The word array `data` has no reset, so preloaded images survive.
module line_mem_responder #(
    parameter int ADDR_BITS   = 32,
    parameter int LINE_BITS   = 128,
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic                 req_write,
    input  logic [LINE_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [LINE_BITS-1:0] resp_data,
    output logic                 resp_write
);

    localparam int WORDS_PER_LINE = 4;
    localparam int WIDX_BITS      = $clog2(DEPTH_WORDS);
    localparam int LIDX_BITS      = WIDX_BITS - 2;

    // Counter reloads with LATENCY-1 so the response appears LATENCY edges
    // after the accepting edge (BUSY spends one edge at count zero).
    localparam logic [7:0] COUNT_INIT = 8'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Word-organised storage; index is {line index, word-in-line}.
    logic [31:0] data [DEPTH_WORDS];

    logic [1:0]           state_reg,      state_next;
    logic [7:0]           count_reg,      count_next;
    logic [LIDX_BITS-1:0] line_reg,       line_next;
    logic                 write_reg,      write_next;
    logic [LINE_BITS-1:0] wdata_reg,      wdata_next;
    logic                 resp_valid_reg, resp_valid_next;
    logic [LINE_BITS-1:0] resp_data_reg,  resp_data_next;
    logic                 resp_write_reg, resp_write_next;

    logic                 accept;
    logic                 fire;
    logic                 release_resp;
    logic                 commit_write;
    logic [LINE_BITS-1:0] rd_line;

    // Only the line-index bits select storage; the byte offset and the bits
    // above the array size are dropped, so large addresses wrap silently.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[3:0], req_addr[ADDR_BITS-1:WIDX_BITS+2]};

    assign accept       = (state_reg == S_IDLE) && req_valid;
    assign fire         = (state_reg == S_BUSY) && (count_reg == 8'd0);
    assign release_resp = (state_reg == S_RESP) && resp_ready;
    assign commit_write = fire && write_reg;

    // Gather the four words of the latched line; word k lands in bits [32k+31:32k].
    generate
        for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_rd_word
            localparam logic [1:0] WSEL = 2'(gi);
            assign rd_line[32*gi +: 32] = data[{line_reg, WSEL}];
        end
    endgenerate

    // Next-state logic for the request/response FSM and its datapath.
    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        line_next       = line_reg;
        write_next      = write_reg;
        wdata_next      = wdata_reg;
        resp_valid_next = resp_valid_reg;
        resp_data_next  = resp_data_reg;
        resp_write_next = resp_write_reg;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    line_next  = req_addr[WIDX_BITS+1:4];
                    write_next = req_write;
                    wdata_next = req_wdata;
                    count_next = COUNT_INIT;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (fire) begin
                    // Reads sample storage here; writes commit on this same edge.
                    resp_data_next  = write_reg ? '0 : rd_line;
                    resp_write_next = write_reg;
                    resp_valid_next = 1'b1;
                    state_next      = S_RESP;
                end else begin
                    count_next = count_reg - 8'd1;
                end
            end
            S_RESP: begin
                // Response held until the initiator takes it; no same-cycle re-accept.
                if (release_resp) begin
                    resp_valid_next = 1'b0;
                    state_next      = S_IDLE;
                end
            end
            default: begin
                state_next      = S_IDLE;
                resp_valid_next = 1'b0;
            end
        endcase
    end

    // Control and response registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            count_reg      <= 8'd0;
            line_reg       <= '0;
            write_reg      <= 1'b0;
            wdata_reg      <= '0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            resp_write_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            line_reg       <= line_next;
            write_reg      <= write_next;
            wdata_reg      <= wdata_next;
            resp_valid_reg <= resp_valid_next;
            resp_data_reg  <= resp_data_next;
            resp_write_reg <= resp_write_next;
        end
    end

    // Storage write port: all four words of the line commit on BUSY->RESP.
    // A reset during BUSY forces IDLE, which suppresses the commit.
    always_ff @(posedge clk) begin
        if (commit_write) begin
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
                data[{line_reg, 2'(k)}] <= wdata_reg[32*k +: 32];
            end
        end
    end

    assign req_ready  = (state_reg == S_IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_write = resp_write_reg;

endmodule

// File: tb/tb_line_mem_responder.sv
// Testbench for line_mem_responder: scoreboard queues filled at issue time,
// drained by per-instance monitors at each response handshake.
module tb_line_mem_responder;

    localparam int LAT_A = 5;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready, a_resp_write;
    logic [31:0]  a_req_addr;
    logic [127:0] a_req_wdata, a_resp_data;
    logic         b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_write;
    logic [31:0]  b_req_addr;
    logic [127:0] b_req_wdata, b_resp_data;

    line_mem_responder #(.ADDR_BITS(32), .LINE_BITS(128), .DEPTH_WORDS(16384), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .req_write(a_req_write), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_data(a_resp_data), .resp_write(a_resp_write)
    );

    line_mem_responder #(.ADDR_BITS(32), .LINE_BITS(128), .DEPTH_WORDS(16384), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .req_write(b_req_write), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_data(b_resp_data), .resp_write(b_resp_write)
    );

    int errors = 0;
    int checks = 0;
    logic [128:0] qa[$];
    logic [128:0] qb[$];
    logic [128:0] ea, eb;

    localparam logic [127:0] LINE_2000 = 128'h12345678_DEADBEEF_00000013_0000006F;
    localparam logic [127:0] LINE_ZERO = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE_80   = 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000;
    localparam logic [127:0] PAT_A     = {4{32'hAAAAAAAA}};
    localparam logic [127:0] PAT_5     = {4{32'h55555555}};
    localparam logic [127:0] LINE_B0   = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] LINE_B1   = 128'h000000B3_000000B2_000000B1_000000B0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor A: compare each response at the cycle its handshake completes.
    always @(negedge clk) begin
        if (!rst && a_resp_valid && a_resp_ready) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_resp: got %h expected no response", a_resp_data);
            end else begin
                ea = qa.pop_front();
                check("a_resp_write", 128'(a_resp_write), 128'(ea[128]));
                check("a_resp_data", a_resp_data, ea[127:0]);
            end
        end
    end

    // Monitor B: same scoreboard scheme for the LATENCY=1 instance.
    always @(negedge clk) begin
        if (!rst && b_resp_valid && b_resp_ready) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_resp: got %h expected no response", b_resp_data);
            end else begin
                eb = qb.pop_front();
                check("b_resp_write", 128'(b_resp_write), 128'(eb[128]));
                check("b_resp_data", b_resp_data, eb[127:0]);
            end
        end
    end

    // Issue one request on A, push its expectation, and measure the latency.
    task automatic issue_a(input logic wr, input logic [31:0] addr, input logic [127:0] wd,
                           input logic [127:0] exp_data, input string name);
        int n;
        n = 0;
        while (!a_req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({name, "_ready"}, 128'(a_req_ready), 128'(1));
        a_req_valid = 1'b1;
        a_req_write = wr;
        a_req_addr  = addr;
        a_req_wdata = wd;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        qa.push_back({wr, wr ? 128'd0 : exp_data});
        n = 0;
        while (!a_resp_valid && n < 300) begin
            @(posedge clk); #1; n++;
        end
        check({name, "_latency"}, 128'(n), 128'(LAT_A));
    endtask

    // Wait (bounded) for the pending A response to be taken.
    task automatic finish_a(input string name);
        int n;
        n = 0;
        while (a_resp_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({name, "_done"}, 128'(a_resp_valid), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_resp_ready = 1;
        b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_resp_ready = 1;

        dut_a.data[2048] = 32'h0000006F; dut_a.data[2049] = 32'h00000013;
        dut_a.data[2050] = 32'hDEADBEEF; dut_a.data[2051] = 32'h12345678;
        dut_a.data[0] = 32'h11111111; dut_a.data[1] = 32'h22222222;
        dut_a.data[2] = 32'h33333333; dut_a.data[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) dut_a.data[32+i] = 32'hC0DE0000 + i;
        for (int i = 0; i < 4; i++) begin
            dut_b.data[i]   = 32'hA0 + i;
            dut_b.data[4+i] = 32'hB0 + i;
        end

        #2;
        check("rst_req_ready", 128'(a_req_ready), 128'(1));
        check("rst_resp_valid", 128'(a_resp_valid), 128'(0));
        check("rst_resp_data", a_resp_data, 128'd0);
        check("rst_resp_write", 128'(a_resp_write), 128'(0));
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Preloaded program image read.
        issue_a(1'b0, 32'h2000, 128'd0, LINE_2000, "t1_read");
        finish_a("t1");

        // Write then read-after-write within the same line.
        issue_a(1'b1, 32'h0040, PAT_A, 128'd0, "t2_write");
        finish_a("t2w");
        for (int i = 0; i < 4; i++) check($sformatf("t2_mem%0d", 16 + i), 128'(dut_a.data[16+i]), 128'(32'hAAAAAAAA));
        issue_a(1'b0, 32'h004C, 128'd0, PAT_A, "t2_read");
        finish_a("t2r");

        // Backpressure: response held stable, stray request ignored.
        a_resp_ready = 1'b0;
        issue_a(1'b0, 32'h2000, 128'd0, LINE_2000, "t3_read");
        for (int i = 0; i < 7; i++) begin
            check("t3_hold_valid", 128'(a_resp_valid), 128'(1));
            check("t3_hold_data", a_resp_data, LINE_2000);
            check("t3_hold_ready", 128'(a_req_ready), 128'(0));
            if (i == 2) begin a_req_valid = 1'b1; a_req_addr = 32'h40; a_req_write = 1'b0; end
            if (i == 3) a_req_valid = 1'b0;
            @(posedge clk); #1;
        end
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_after_valid", 128'(a_resp_valid), 128'(0));
        check("t3_after_ready", 128'(a_req_ready), 128'(1));
        seen = 0;
        repeat (LAT_A + 3) begin
            @(posedge clk); #1;
            if (a_resp_valid) seen = 1;
        end
        check("t3_stray_ignored", 128'(seen), 128'(0));

        // Address wrap: 0x0001_0000 aliases word 0.
        issue_a(1'b0, 32'h0001_0000, 128'd0, LINE_ZERO, "t4_wrap");
        finish_a("t4w");
        issue_a(1'b0, 32'h0000_0000, 128'd0, LINE_ZERO, "t4_zero");
        finish_a("t4z");

        // Reset two cycles into BUSY of a write: no commit.
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h80; a_req_wdata = PAT_5;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t5_rst_req_ready", 128'(a_req_ready), 128'(1));
        check("t5_rst_resp_valid", 128'(a_resp_valid), 128'(0));
        check("t5_rst_resp_data", a_resp_data, 128'd0);
        check("t5_rst_resp_write", 128'(a_resp_write), 128'(0));
        #2 rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) check($sformatf("t5_mem%0d", 32 + i), 128'(dut_a.data[32+i]), 128'(32'hC0DE0000 + i));
        issue_a(1'b0, 32'h0080, 128'd0, LINE_80, "t5_read");
        finish_a("t5r");

        // LATENCY=1 back-to-back reads on instance B.
        check("b_idle_ready", 128'(b_req_ready), 128'(1));
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h0;
        qb.push_back({1'b0, LINE_B0});
        @(posedge clk); #1;
        b_req_addr = 32'h10;
        check("b_busy0_valid", 128'(b_resp_valid), 128'(0));
        @(posedge clk); #1;
        check("b_lat0_valid", 128'(b_resp_valid), 128'(1));
        check("b_lat0_ready", 128'(b_req_ready), 128'(0));
        qb.push_back({1'b0, LINE_B1});
        @(posedge clk); #1;
        check("b_hs0_valid", 128'(b_resp_valid), 128'(0));
        check("b_next_accept_ready", 128'(b_req_ready), 128'(1));
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        check("b_busy1_ready", 128'(b_req_ready), 128'(0));
        @(posedge clk); #1;
        check("b_lat1_valid", 128'(b_resp_valid), 128'(1));
        @(posedge clk); #1;
        check("b_hs1_valid", 128'(b_resp_valid), 128'(0));
        check("b_hs1_ready", 128'(b_req_ready), 128'(1));

        repeat (2) @(posedge clk);
        #1;
        check("qa_drained", 128'(qa.size()), 128'(0));
        check("qb_drained", 128'(qb.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
